mips_multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It decodes the instruction opcode and sequences every datapath step: fetch, decode, address/execute, memory access and write-back. It drives `aluop` into the ALU control unit (which combines it with the function field) plus all mux selects and write strobes. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/mips_multicycle_control.sv | 139 +++++++++++++
 tb/tb_mips_multicycle_control.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM sequencing the multicycle MIPS datapath with memory-ready stalls
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t state_q, state_d;
  always_ff @(posedge clk)
    state_q <= reset ? FETCH : state_d;
  assign state = state_q;
  always_comb begin
    state_d    = FETCH;
    aluop      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    pcen       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        pcen       = zero;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // reset abandons any instruction in flight, so every strobe is gated off
    if (reset) begin
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      pcen       = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed checks of state sequencing, control outputs and strobes
module tb_mips_multicycle_control;
  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op;
  logic [1:0] aluop, alusrcb, pcsrc;
  logic       alusrca, iord, regdst, memtoreg;
  logic       irwrite, memwrite, regwrite, pcen, instr_done, illegal;
  logic [3:0] state;
  logic [5:0] strb;
  int checks = 0, errors = 0;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .irwrite(irwrite),
    .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;
  // {irwrite, memwrite, regwrite, pcen, instr_done, illegal}
  assign strb = {irwrite, memwrite, regwrite, pcen, instr_done, illegal};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [3:0] s, input logic [5:0] sb);
    #1;
    chk({tag, "_state"}, {4'd0, state}, {4'd0, s});
    chk({tag, "_strb"}, {2'd0, strb}, {2'd0, sb});
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 6'b000000; zero = 1'b0;
    tick(); tick(); tick();
    st("reset", 4'd0, 6'b000000);
    chk("reset_alusrcb", {6'd0, alusrcb}, 8'h01);
    chk("reset_misc", {2'd0, aluop, pcsrc, alusrca, iord}, 8'h00);
    reset = 1'b0;
    st("fetch1", 4'd0, 6'b100100);
    chk("fetch1_alusrcb", {6'd0, alusrcb}, 8'h01);
    // R-type
    tick(); st("r_dec", 4'd1, 6'b000000);
    chk("r_dec_alusrcb", {6'd0, alusrcb}, 8'h03);
    tick(); st("r_exe", 4'd6, 6'b000000);
    chk("r_exe_ctl", {3'd0, aluop, alusrca, alusrcb}, {3'd0, 2'b10, 1'b1, 2'b00});
    tick(); st("r_wb", 4'd7, 6'b001010);
    chk("r_wb_dst", {6'd0, regdst, memtoreg}, 8'h02);
    tick(); st("r_done", 4'd0, 6'b100100);
    // lw with two MEMRD stall cycles
    op = 6'b100011;
    tick(); st("lw_dec", 4'd1, 6'b000000);
    tick(); st("lw_adr", 4'd2, 6'b000000);
    chk("lw_adr_ctl", {5'd0, alusrca, alusrcb}, {5'd0, 1'b1, 2'b10});
    tick(); mem_ready = 1'b0; st("lw_rd0", 4'd3, 6'b000000);
    chk("lw_rd_iord", {7'd0, iord}, 8'h01);
    tick(); st("lw_rd1", 4'd3, 6'b000000);
    tick(); mem_ready = 1'b1; st("lw_rd2", 4'd3, 6'b000000);
    tick(); st("lw_wb", 4'd4, 6'b001010);
    chk("lw_wb_dst", {6'd0, regdst, memtoreg}, 8'h01);
    tick(); st("lw_done", 4'd0, 6'b100100);
    // sw with one MEMWR stall cycle
    op = 6'b101011;
    tick(); st("sw_dec", 4'd1, 6'b000000);
    tick(); st("sw_adr", 4'd2, 6'b000000);
    tick(); mem_ready = 1'b0; st("sw_wr0", 4'd5, 6'b010000);
    chk("sw_wr_iord", {7'd0, iord}, 8'h01);
    tick(); mem_ready = 1'b1; st("sw_wr1", 4'd5, 6'b010010);
    tick(); st("sw_done", 4'd0, 6'b100100);
    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    tick(); st("beq1_dec", 4'd1, 6'b000000);
    tick(); st("beq1_br", 4'd8, 6'b000110);
    chk("beq1_ctl", {2'd0, aluop, pcsrc, alusrca, 1'b0}, {2'd0, 2'b01, 2'b01, 1'b1, 1'b0});
    tick(); st("beq1_done", 4'd0, 6'b100100);
    zero = 1'b0;
    tick(); st("beq0_dec", 4'd1, 6'b000000);
    tick(); st("beq0_br", 4'd8, 6'b000010);
    tick(); st("beq0_done", 4'd0, 6'b100100);
    // addi, with mem_ready low while in DECODE (must be ignored)
    op = 6'b001000;
    tick(); mem_ready = 1'b0; st("addi_dec", 4'd1, 6'b000000);
    tick(); mem_ready = 1'b1; st("addi_ex", 4'd9, 6'b000000);
    chk("addi_ex_ctl", {3'd0, aluop, alusrca, alusrcb}, {3'd0, 2'b00, 1'b1, 2'b10});
    tick(); st("addi_wb", 4'd10, 6'b001010);
    chk("addi_wb_dst", {6'd0, regdst, memtoreg}, 8'h00);
    tick(); st("addi_done", 4'd0, 6'b100100);
    // jump
    op = 6'b000010;
    tick(); st("j_dec", 4'd1, 6'b000000);
    tick(); st("j_jmp", 4'd11, 6'b000110);
    chk("j_pcsrc", {6'd0, pcsrc}, 8'h02);
    tick(); st("j_done", 4'd0, 6'b100100);
    // illegal opcode
    op = 6'b111111;
    tick(); st("ill_dec", 4'd1, 6'b000001);
    tick(); st("ill_done", 4'd0, 6'b100100);
    // FETCH stall
    mem_ready = 1'b0; st("fetch_stall", 4'd0, 6'b000000);
    tick(); mem_ready = 1'b1; st("fetch_stall2", 4'd0, 6'b100100);
    // reset during MEMWR wait
    op = 6'b101011;
    tick(); tick(); tick(); mem_ready = 1'b0; st("rst_wr", 4'd5, 6'b010000);
    reset = 1'b1; st("rst_wr_gate", 4'd5, 6'b000000);
    tick(); st("rst_wr_state", 4'd0, 6'b000000);
    reset = 1'b0; mem_ready = 1'b1; st("rst_rel", 4'd0, 6'b100100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
